// File: rtl/csb_seq.sv
// csb_seq: command sequencer. Pulls fixed-length command records from a
// first-word-fall-through FIFO, decodes them into layer attributes, checks
// them, dispatches each one to the conv or the pool engine, and counts
// completions against the host-supplied command count before raising irq.
//
// Handshakes:
//   FIFO   : a word is consumed on a rising edge where valid && rd_en.
//            rd_en is combinational and high for every cycle spent in FETCH.
//   Engine : eng_valid[sel] rises when the command is issued and stays high
//            until the one-cycle done pulse eng_ready[sel] is sampled. The
//            ready bit of the engine that was not selected is ignored.
// curr_state exposes the FSM state: IDLE 0, FETCH 1, ISSUE 2, RUN 3,
// DONE 4, ERROR 5.
module csb_seq #(
  parameter int CMD_WORDS = 3,
  parameter int CNT_W     = 7,
  parameter int TMO_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_en,
  input  logic             irq_clr,
  input  logic [CNT_W-1:0] cmd_size,
  input  logic             valid,
  output logic             rd_en,
  input  logic [31:0]      cmd,
  output logic [2:0]       op_type,
  output logic [3:0]       stride,
  output logic [7:0]       kernel,
  output logic [7:0]       i_side,
  output logic [7:0]       o_side,
  output logic [15:0]      i_channel,
  output logic [15:0]      o_channel,
  output logic [7:0]       kernel_size,
  output logic [15:0]      stride2,
  output logic [1:0]       eng_valid,
  input  logic [1:0]       eng_ready,
  output logic             engine_reset,
  output logic [2:0]       curr_state,
  output logic [CNT_W-1:0] done_count,
  output logic             irq,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int WW = $clog2(CMD_WORDS);
  localparam logic [WW-1:0] W_LAST = WW'(CMD_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [WW-1:0]      w_q, w_d;
  logic [CNT_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]   dc_q, dc_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               sel_q, sel_d;
  logic [1:0]         ev_q, ev_d;
  logic               erst_q, erst_d;
  logic               irq_q, irq_d;
  logic               err_q, err_d;
  logic [1:0]         ecode_q, ecode_d;
  logic [2:0]         op_type_q, op_type_d;
  logic [3:0]         stride_q, stride_d;
  logic [7:0]         kernel_q, kernel_d;
  logic [7:0]         i_side_q, i_side_d;
  logic [7:0]         o_side_q, o_side_d;
  logic [15:0]        i_channel_q, i_channel_d;
  logic [15:0]        o_channel_q, o_channel_d;
  logic [7:0]         kernel_size_q, kernel_size_d;
  logic [15:0]        stride2_q, stride2_d;

  // Decode helpers shared by the next-state and output processes.
  logic             op_conv, op_pool, op_ok, geom_bad, eng_done, last_word;
  logic [CNT_W-1:0] cnt_inc;
  logic [TMO_W-1:0] wdog_inc;

  assign op_conv   = (op_type_q == 3'b001);
  assign op_pool   = (op_type_q == 3'b100) || (op_type_q == 3'b101);
  assign op_ok     = op_conv || op_pool;
  assign geom_bad  = (kernel_q == 8'd0) || (stride_q == 4'd0) ||
                     ({4'd0, stride_q} > kernel_q);
  assign eng_done  = eng_ready[sel_q];
  assign last_word = (w_q == W_LAST);
  assign cnt_inc   = dc_q + CNT_W'(1);
  assign wdog_inc  = wdog_q + TMO_W'(1);

  // State register plus all registered outputs and bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      w_q           <= '0;
      size_q        <= '0;
      dc_q          <= '0;
      wdog_q        <= '0;
      sel_q         <= 1'b0;
      ev_q          <= 2'b00;
      erst_q        <= 1'b1;
      irq_q         <= 1'b0;
      err_q         <= 1'b0;
      ecode_q       <= 2'd0;
      op_type_q     <= '0;
      stride_q      <= '0;
      kernel_q      <= '0;
      i_side_q      <= '0;
      o_side_q      <= '0;
      i_channel_q   <= '0;
      o_channel_q   <= '0;
      kernel_size_q <= '0;
      stride2_q     <= '0;
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      size_q        <= size_d;
      dc_q          <= dc_d;
      wdog_q        <= wdog_d;
      sel_q         <= sel_d;
      ev_q          <= ev_d;
      erst_q        <= erst_d;
      irq_q         <= irq_d;
      err_q         <= err_d;
      ecode_q       <= ecode_d;
      op_type_q     <= op_type_d;
      stride_q      <= stride_d;
      kernel_q      <= kernel_d;
      i_side_q      <= i_side_d;
      o_side_q      <= o_side_d;
      i_channel_q   <= i_channel_d;
      o_channel_q   <= o_channel_d;
      kernel_size_q <= kernel_size_d;
      stride2_q     <= stride2_d;
    end
  end

  // Next-state logic; ISSUE checks op_type before the geometry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_en) state_d = (cmd_size != '0) ? S_FETCH : S_DONE;
      S_FETCH: if (valid && last_word) state_d = S_ISSUE;
      S_ISSUE: state_d = (!op_ok || geom_bad) ? S_ERROR : S_RUN;
      S_RUN: begin
        if (eng_done)               state_d = (cnt_inc == size_q) ? S_DONE : S_FETCH;
        else if (wdog_inc == '1)    state_d = S_ERROR;
      end
      S_DONE, S_ERROR: if (irq_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: field decode, dispatch, counting, irq/err.
  always_comb begin
    w_d           = w_q;
    size_d        = size_q;
    dc_d          = dc_q;
    wdog_d        = wdog_q;
    sel_d         = sel_q;
    ev_d          = ev_q;
    erst_d        = erst_q;
    irq_d         = irq_q;
    err_d         = err_q;
    ecode_d       = ecode_q;
    op_type_d     = op_type_q;
    stride_d      = stride_q;
    kernel_d      = kernel_q;
    i_side_d      = i_side_q;
    o_side_d      = o_side_q;
    i_channel_d   = i_channel_q;
    o_channel_d   = o_channel_q;
    kernel_size_d = kernel_size_q;
    stride2_d     = stride2_q;
    case (state_q)
      S_IDLE: begin
        if (op_en) begin
          size_d = cmd_size;
          // A zero-length job completes immediately without touching the FIFO.
          if (cmd_size == '0) irq_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (valid) begin
          if (w_q == WW'(0)) begin
            op_type_d = cmd[2:0];
            stride_d  = cmd[7:4];
            kernel_d  = cmd[15:8];
            i_side_d  = cmd[23:16];
            o_side_d  = cmd[31:24];
          end else if (w_q == WW'(1)) begin
            i_channel_d = cmd[15:0];
            o_channel_d = cmd[31:16];
          end else if (w_q == WW'(2)) begin
            kernel_size_d = cmd[15:8];
            stride2_d     = cmd[31:16];
          end
          // Words past the third are consumed but carry nothing we keep.
          w_d = last_word ? '0 : w_q + WW'(1);
        end
      end
      S_ISSUE: begin
        if (!op_ok) begin
          irq_d   = 1'b1;
          err_d   = 1'b1;
          ecode_d = 2'd1;
        end else if (geom_bad) begin
          irq_d   = 1'b1;
          err_d   = 1'b1;
          ecode_d = 2'd2;
        end else begin
          sel_d  = op_pool;
          ev_d   = op_pool ? 2'b10 : 2'b01;
          erst_d = 1'b0;
          wdog_d = '0;
        end
      end
      S_RUN: begin
        if (eng_done) begin
          ev_d   = 2'b00;
          erst_d = 1'b1;
          dc_d   = cnt_inc;
          wdog_d = '0;
          if (cnt_inc == size_q) irq_d = 1'b1;
        end else if (wdog_inc == '1) begin
          ev_d    = 2'b00;
          erst_d  = 1'b1;
          wdog_d  = wdog_inc;
          irq_d   = 1'b1;
          err_d   = 1'b1;
          ecode_d = 2'd3;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_DONE, S_ERROR: begin
        if (irq_clr) begin
          irq_d   = 1'b0;
          err_d   = 1'b0;
          ecode_d = 2'd0;
          dc_d    = '0;
          wdog_d  = '0;
        end
      end
      default: ;
    endcase
  end

  assign rd_en        = (state_q == S_FETCH);
  assign curr_state   = state_q;
  assign eng_valid    = ev_q;
  assign engine_reset = erst_q;
  assign done_count   = dc_q;
  assign irq          = irq_q;
  assign err          = err_q;
  assign err_code     = ecode_q;
  assign op_type      = op_type_q;
  assign stride       = stride_q;
  assign kernel       = kernel_q;
  assign i_side       = i_side_q;
  assign o_side       = o_side_q;
  assign i_channel    = i_channel_q;
  assign o_channel    = o_channel_q;
  assign kernel_size  = kernel_size_q;
  assign stride2      = stride2_q;

endmodule

// File: tb/tb_csb_seq.sv
// Testbench for csb_seq: table of single-command records plus directed
// sequences for multi-command, gapped FIFO, watchdog, zero size and reset.
module tb_csb_seq;

  localparam int CW    = 4;
  localparam int CNT_W = 7;
  localparam int TMO_W = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             op_en, irq_clr, valid, rd_en;
  logic [CNT_W-1:0] cmd_size;
  logic [31:0]      cmd;
  logic [2:0]       op_type;
  logic [3:0]       stride;
  logic [7:0]       kernel, i_side, o_side, kernel_size;
  logic [15:0]      i_channel, o_channel, stride2;
  logic [1:0]       eng_valid, eng_ready, err_code;
  logic             engine_reset, irq, err;
  logic [2:0]       curr_state;
  logic [CNT_W-1:0] done_count;

  csb_seq #(.CMD_WORDS(CW), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_en(op_en), .irq_clr(irq_clr),
    .cmd_size(cmd_size), .valid(valid), .rd_en(rd_en), .cmd(cmd),
    .op_type(op_type), .stride(stride), .kernel(kernel), .i_side(i_side),
    .o_side(o_side), .i_channel(i_channel), .o_channel(o_channel),
    .kernel_size(kernel_size), .stride2(stride2), .eng_valid(eng_valid),
    .eng_ready(eng_ready), .engine_reset(engine_reset),
    .curr_state(curr_state), .done_count(done_count), .irq(irq),
    .err(err), .err_code(err_code)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int rd_bad = 0;
  logic [1:0] exp_q[$];   // expected eng_valid value of each dispatch, in order
  logic [1:0] prev_ev = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Dispatch monitor: every rising eng_valid must match the next expected grant.
  always @(negedge clk) begin
    if (rst_n && eng_valid != 2'b00 && prev_ev == 2'b00) begin
      if (exp_q.size() == 0) check("unexpected_dispatch", {30'd0, eng_valid}, 32'd0);
      else                   check("dispatch_order", {30'd0, eng_valid}, {30'd0, exp_q.pop_front()});
    end
    prev_ev = eng_valid;
    if (rd_en && curr_state != 3'd1) rd_bad++;
  end

  // ---------------- FIFO model (first-word-fall-through) ----------------
  logic [31:0] fifo_q[$];
  int words_read = 0;
  bit gap_mode = 1'b0;
  int gap_cnt = 0;

  always @(posedge clk) begin
    if (rst_n && valid && rd_en && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      words_read++;
    end
  end

  always @(negedge clk) begin
    valid = (fifo_q.size() > 0) && (!gap_mode || (gap_cnt % 3 == 0));
    cmd   = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
    gap_cnt++;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] w0, w1, w2;
    logic [1:0]  exp_ev;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] mk_w0(input logic [2:0] op, input logic [3:0] s,
                                        input logic [7:0] k, input logic [7:0] is,
                                        input logic [7:0] os);
    return {os, is, k, s, 1'b0, op};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    for (int i = 3; i < CW; i++) fifo_q.push_back(32'hDEAD_BEEF);
  endtask

  task automatic start(input logic [CNT_W-1:0] n);
    op_en    = 1'b1;
    cmd_size = n;
    @(negedge clk);
    op_en    = 1'b0;
  endtask

  task automatic pulse_ready(input logic [1:0] r);
    eng_ready = r;
    @(negedge clk);
    eng_ready = 2'b00;
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("clr_state", {29'd0, curr_state}, 32'd0);
    check("clr_irq", {31'd0, irq}, 32'd0);
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_code", {30'd0, err_code}, 32'd0);
    check("clr_done_count", {25'd0, done_count}, 32'd0);
  endtask

  // Waits for eng_valid; returns cycle index (1 = first cycle after start) or 0 on timeout.
  task automatic wait_ev(output int c);
    c = 0;
    for (int i = 1; i <= 200; i++) begin
      if (eng_valid != 2'b00) begin
        c = i;
        break;
      end
      @(negedge clk);
    end
    if (c == 0) check("wait_eng_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_fields(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2);
    check({tag, "_op_type"}, {29'd0, op_type}, {29'd0, w0[2:0]});
    check({tag, "_stride"}, {28'd0, stride}, {28'd0, w0[7:4]});
    check({tag, "_kernel"}, {24'd0, kernel}, {24'd0, w0[15:8]});
    check({tag, "_i_side"}, {24'd0, i_side}, {24'd0, w0[23:16]});
    check({tag, "_o_side"}, {24'd0, o_side}, {24'd0, w0[31:24]});
    check({tag, "_i_channel"}, {16'd0, i_channel}, {16'd0, w1[15:0]});
    check({tag, "_o_channel"}, {16'd0, o_channel}, {16'd0, w1[31:16]});
    check({tag, "_kernel_size"}, {24'd0, kernel_size}, {24'd0, w2[15:8]});
    check({tag, "_stride2"}, {16'd0, stride2}, {16'd0, w2[31:16]});
  endtask

  // One single-command job with continuous valid, checked cycle by cycle.
  task automatic run_vec(input vec_t v);
    int w_start;
    push_cmd(v.w0, v.w1, v.w2);
    if (v.exp_code == 2'd0) exp_q.push_back(v.exp_ev);
    w_start = words_read;
    start(1);
    check("vec_fetch_state", {29'd0, curr_state}, 32'd1);
    check("vec_rd_en", {31'd0, rd_en}, 32'd1);
    repeat (CW) @(negedge clk);
    check("vec_issue_state", {29'd0, curr_state}, 32'd2);
    @(negedge clk);
    check_fields("vec", v.w0, v.w1, v.w2);
    check("vec_words", words_read - w_start, CW);
    check("vec_err_code", {30'd0, err_code}, {30'd0, v.exp_code});
    check("vec_eng_valid", {30'd0, eng_valid}, {30'd0, v.exp_ev});
    if (v.exp_code == 2'd0) begin
      check("vec_run_state", {29'd0, curr_state}, 32'd3);
      check("vec_engine_reset_run", {31'd0, engine_reset}, 32'd0);
      check("vec_irq_run", {31'd0, irq}, 32'd0);
      pulse_ready(v.exp_ev);
      check("vec_done_state", {29'd0, curr_state}, 32'd4);
      check("vec_done_count", {25'd0, done_count}, 32'd1);
      check("vec_irq_done", {31'd0, irq}, 32'd1);
      check("vec_err_done", {31'd0, err}, 32'd0);
      check("vec_ev_done", {30'd0, eng_valid}, 32'd0);
    end else begin
      check("vec_error_state", {29'd0, curr_state}, 32'd5);
      check("vec_irq_error", {31'd0, irq}, 32'd1);
      check("vec_err_error", {31'd0, err}, 32'd1);
    end
    check("vec_engine_reset_end", {31'd0, engine_reset}, 32'd1);
    clear_irq();
    check("vec_fields_kept", {16'd0, i_channel}, {16'd0, v.w1[15:0]});
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  // ---------------- main test ----------------
  initial begin
    int c, c2, run_cycles, w0cnt;
    logic [31:0] a0, a1, a2, b0, b1, b2;

    rst_n = 1'b0; op_en = 1'b0; irq_clr = 1'b0; cmd_size = '0;
    eng_ready = 2'b00; valid = 1'b0; cmd = 32'd0;

    vecs[0] = '{mk_w0(3'b001, 4'd1, 8'd3, 8'd28, 8'd26), 32'h0040_0020, 32'h0002_03AA, 2'b01, 2'd0};
    vecs[1] = '{mk_w0(3'b100, 4'd2, 8'd2, 8'd26, 8'd13), 32'h0040_0040, 32'h0007_0255, 2'b10, 2'd0};
    vecs[2] = '{mk_w0(3'b101, 4'd3, 8'd8, 8'h80, 8'h2A), 32'h1234_5678, 32'hBEEF_08C3, 2'b10, 2'd0};
    vecs[3] = '{mk_w0(3'b011, 4'd1, 8'd3, 8'd10, 8'd10), 32'h0001_0002, 32'h0003_0300, 2'b00, 2'd1};
    vecs[4] = '{mk_w0(3'b001, 4'd4, 8'd3, 8'd10, 8'd10), 32'h0001_0002, 32'h0003_0300, 2'b00, 2'd2};
    vecs[5] = '{mk_w0(3'b100, 4'd0, 8'd0, 8'd5, 8'd5), 32'hAAAA_5555, 32'h0000_0000, 2'b00, 2'd2};
    vecs[6] = '{mk_w0(3'b001, 4'd0, 8'd5, 8'd7, 8'd7), 32'h0F0F_F0F0, 32'hFFFF_FF00, 2'b00, 2'd2};
    vecs[7] = '{mk_w0(3'b000, 4'd0, 8'd0, 8'd1, 8'd1), 32'h0000_0001, 32'h0001_0100, 2'b00, 2'd1};
    vecs[8] = '{mk_w0(3'b111, 4'd4, 8'd3, 8'd2, 8'd2), 32'h0002_0003, 32'h0004_0500, 2'b00, 2'd1};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_state", {29'd0, curr_state}, 32'd0);
    check("rst_engine_reset", {31'd0, engine_reset}, 32'd1);
    check("rst_eng_valid", {30'd0, eng_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_done_count", {25'd0, done_count}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single-command vectors
    foreach (vecs[i]) run_vec(vecs[i]);

    // Two commands: conv then maxpool, ready 10 cycles after each grant
    a0 = mk_w0(3'b001, 4'd1, 8'd3, 8'd32, 8'd30); a1 = 32'h0010_0003; a2 = 32'h0001_0300;
    b0 = mk_w0(3'b100, 4'd2, 8'd2, 8'd30, 8'd15); b1 = 32'h0010_0010; b2 = 32'h0002_0200;
    push_cmd(a0, a1, a2);
    push_cmd(b0, b1, b2);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    start(2);
    wait_ev(c);
    check("seq_latency_1", c, CW + 2);
    check_fields("seq1", a0, a1, a2);
    repeat (4) @(negedge clk);
    eng_ready = 2'b10;          // wrong engine: must be ignored
    irq_clr   = 1'b1;           // outside DONE/ERROR: must be ignored
    op_en     = 1'b1;           // outside IDLE: must be ignored
    @(negedge clk);
    eng_ready = 2'b00; irq_clr = 1'b0; op_en = 1'b0;
    check("seq_wrong_ready_ev", {30'd0, eng_valid}, 32'd1);
    check("seq_wrong_ready_state", {29'd0, curr_state}, 32'd3);
    repeat (5) @(negedge clk);
    pulse_ready(2'b01);
    check("seq_next_fetch", {29'd0, curr_state}, 32'd1);
    check("seq_next_rd_en", {31'd0, rd_en}, 32'd1);
    check("seq_ev_low", {30'd0, eng_valid}, 32'd0);
    check("seq_count_1", {25'd0, done_count}, 32'd1);
    wait_ev(c2);
    check("seq_latency_2", c2, CW + 2);
    check_fields("seq2", b0, b1, b2);
    repeat (10) @(negedge clk);
    check("seq_hold_ev", {30'd0, eng_valid}, 32'd2);
    pulse_ready(2'b10);
    check("seq_done_state", {29'd0, curr_state}, 32'd4);
    check("seq_count_2", {25'd0, done_count}, 32'd2);
    check("seq_irq", {31'd0, irq}, 32'd1);
    check("seq_err", {31'd0, err}, 32'd0);
    clear_irq();

    // Gapped valid: one word every 3rd cycle
    gap_mode = 1'b1;
    a0 = mk_w0(3'b101, 4'd2, 8'd4, 8'd9, 8'd4); a1 = 32'hCAFE_0101; a2 = 32'h7777_1100;
    push_cmd(a0, a1, a2);
    exp_q.push_back(2'b10);
    w0cnt = words_read;
    start(1);
    wait_ev(c);
    check("gap_stalls", {31'd0, (c > CW + 2)}, 32'd1);
    check("gap_words", words_read - w0cnt, CW);
    check("gap_rd_en_run", {31'd0, rd_en}, 32'd0);
    check_fields("gap", a0, a1, a2);
    pulse_ready(2'b10);
    check("gap_done", {29'd0, curr_state}, 32'd4);
    clear_irq();
    gap_mode = 1'b0;

    // Watchdog: engine never answers
    push_cmd(vecs[0].w0, vecs[0].w1, vecs[0].w2);
    exp_q.push_back(2'b01);
    start(1);
    wait_ev(c);
    run_cycles = 0;
    while (curr_state == 3'd3 && run_cycles < 100) begin
      run_cycles++;
      @(negedge clk);
    end
    check("wdog_run_cycles", run_cycles, 15);
    check("wdog_state", {29'd0, curr_state}, 32'd5);
    check("wdog_code", {30'd0, err_code}, 32'd3);
    check("wdog_engine_reset", {31'd0, engine_reset}, 32'd1);
    check("wdog_ev", {30'd0, eng_valid}, 32'd0);
    check("wdog_irq_err", {30'd0, irq, err}, 32'd3);
    clear_irq();

    // Zero-size job: straight to DONE, FIFO untouched
    fifo_q.push_back(32'h0000_1111);
    w0cnt = words_read;
    start(0);
    check("zero_state", {29'd0, curr_state}, 32'd4);
    check("zero_irq", {31'd0, irq}, 32'd1);
    check("zero_rd_en", {31'd0, rd_en}, 32'd0);
    @(negedge clk);
    check("zero_words", words_read - w0cnt, 0);
    clear_irq();
    fifo_q.delete();
    @(negedge clk);

    // Asynchronous reset during RUN
    push_cmd(vecs[1].w0, vecs[1].w1, vecs[1].w2);
    exp_q.push_back(2'b10);
    start(1);
    wait_ev(c);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {29'd0, curr_state}, 32'd0);
    check("arst_ev", {30'd0, eng_valid}, 32'd0);
    check("arst_engine_reset", {31'd0, engine_reset}, 32'd1);
    check("arst_op_type", {29'd0, op_type}, 32'd0);
    check("arst_i_channel", {16'd0, i_channel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fifo_q.delete();
    @(negedge clk);
    run_vec(vecs[0]);

    // End-of-run scoreboard checks
    check("exp_q_drained", exp_q.size(), 0);
    check("rd_en_outside_fetch", rd_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csb_seq.md
# csb_seq

Parametrised command sequencer for the accelerator core, successor of the single-engine command scheduler. Pulls fixed-length command records from the command FIFO and decodes them into layer attributes. Dispatches each command to a conv engine or a pool engine over separate valid/ready channels, counts completions against the host-supplied command count and raises an interrupt. Adds parameter checking, a run watchdog and interrupt clear with return to idle.

## Interface
Parameters:
- CMD_WORDS, 3, 32-bit FIFO words per command record; must be ≥3; words beyond the third are read and discarded
- CNT_W, 7, width of command count and completion counter
- TMO_W, 16, width of the RUN watchdog counter

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_en  in  1  start request; sampled only in IDLE
- irq_clr  in  1  clears irq/err and returns to IDLE; sampled only in DONE/ERROR
- cmd_size  in  CNT_W  number of commands to execute; sampled when op_en is accepted
- valid  in  1  FIFO data available (first-word-fall-through)
- rd_en  out  1  FIFO read; word consumed on an edge with valid && rd_en
- cmd  in  32  FIFO data
- op_type  out  3 / stride  out  4 / kernel  out  8 / i_side  out  8 / o_side  out  8  decoded from word 0
- i_channel  out  16 / o_channel  out  16  decoded from word 1
- kernel_size  out  8 / stride2  out  16  decoded from word 2
- eng_valid  out  2  bit0 conv engine, bit1 pool engine
- eng_ready  in  2  one-cycle done pulse per engine
- engine_reset  out  1  high except from ISSUE through completion of the current command
- curr_state  out  3  state encoding below
- done_count  out  CNT_W  commands completed
- irq  out  1 / err  out  1 / err_code  out  2

## Operation
- States: IDLE 0, FETCH 1, ISSUE 2, RUN 3, DONE 4, ERROR 5.
- IDLE: op_en && cmd_size≠0 → FETCH, latching cmd_size. op_en && cmd_size==0 → DONE.
- FETCH: rd_en = (state==FETCH), combinational.
  - Word index w counts 0..CMD_WORDS-1 and advances on each accepted word.
  - w0: op_type=cmd[2:0], stride=cmd[7:4], kernel=cmd[15:8], i_side=cmd[23:16], o_side=cmd[31:24].
  - w1: i_channel=cmd[15:0], o_channel=cmd[31:16].
  - w2: kernel_size=cmd[15:8], stride2=cmd[31:16].
  - When word CMD_WORDS-1 is accepted → ISSUE, and w resets to 0.
  - No valid: stay in FETCH, no timeout.
- ISSUE (one cycle) → RUN, with engine_reset←0 and eng_valid[sel]←1. Checks first, in priority order:
  - op_type 001 selects conv (sel 0); 100 or 101 selects pool (sel 1). Any other op_type → ERROR, err_code 1.
  - kernel==0, stride==0, or stride>kernel → ERROR, err_code 2.
- RUN:
  - eng_valid[sel] is held high until eng_ready[sel]. The ready bit of the non-selected engine is ignored.
  - On eng_ready[sel]: eng_valid←0, engine_reset←1, done_count+1, watchdog←0. If the new count equals the latched cmd_size → DONE, else → FETCH.
  - Watchdog counts cycles in RUN. At all-ones: → ERROR, err_code 3, eng_valid←0, engine_reset←1.
- DONE: irq=1.
- ERROR: irq=1, err=1.
- DONE/ERROR + irq_clr → IDLE. Clears irq, err, err_code, done_count and the watchdog. Decoded fields keep their values.
- op_en outside IDLE and irq_clr outside DONE/ERROR are ignored.
- done_count wraps modulo 2^CNT_W; it cannot exceed cmd_size.

## Timing
- Reset values: all outputs 0, except engine_reset=1. curr_state=IDLE. The internal word index, watchdog and latched size are also 0.
- Reset asserted mid-operation returns to IDLE immediately. Any in-flight command is abandoned and the FIFO is not drained.
- Latency with op_en at edge 0 and valid continuous:
  - FETCH occupies cycles 1..CMD_WORDS.
  - ISSUE occupies cycle CMD_WORDS+1.
  - eng_valid is high from cycle CMD_WORDS+2.
- eng_ready at edge t: eng_valid is low and state is FETCH/DONE in cycle t+1. For a next command, rd_en is high in cycle t+1.
- irq rises the cycle after entry to DONE/ERROR is decided and holds until irq_clr. It falls in the cycle after irq_clr is sampled.
- All outputs are registered except rd_en.

## Test plan
- cmd_size=2: conv record then maxpool record (op 001 k=3 s=1; op 100 k=2 s=2), valid continuous, ready 10 cycles after each eng_valid → eng_valid bit0 then bit1 asserted, fields match, done_count=2, irq high, err=0; irq_clr → IDLE, done_count=0.
- valid gapped to every 3rd cycle → exactly CMD_WORDS words consumed per command, rd_en low outside FETCH, fields correct.
- op_type=011 → ERROR with err_code=1, eng_valid never high; op 001 k=3 s=4 → err_code=2.
- Engine never responds with TMO_W=4 → ERROR, err_code=3, after 15 RUN cycles; engine_reset=1.
- Pulse eng_ready[1] while conv is selected → ignored, eng_valid[0] stays high; op_en=1 with cmd_size=0 → DONE and irq without reading the FIFO.
- rst_n low during RUN → all outputs at reset values asynchronously; op_en after release runs a full command normally.
